etapa_if: RTL
=============

ETAPA_IF -- requirements
Module: etapa_if

Interface
REQ-001 Parameters SHALL be: NBITS, default 32, datapath/PC width; IMEM_DEPTH, default 256, instruction memory words; HALT_WORD, default 32'hFFFF_FFFF, halt instruction encoding.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 i_enable  in  1  run enable from debug unit.
REQ-005 i_step  in  1  single-step request, one-cycle pulse.
REQ-006 i_load_we  in  1  instruction memory write strobe; i_load_addr  in  log2(IMEM_DEPTH)  word address; i_load_data  in  NBITS  word.
REQ-007 i_stall  in  1  hazard-unit stall (hold PC).
REQ-008 i_branch  in  1  branch taken; i_branch_target  in  NBITS  byte address.
REQ-009 i_jump  in  1  jump taken; i_jump_target  in  NBITS  byte address.
REQ-010 o_PC, o_PC4, o_PC8, o_Instruction  out  NBITS  each  current PC, PC+4, PC+8, fetched word (feed IF/ID latch).
REQ-011 o_halt  out  1  halt reached; o_state  out  2  FSM state for debug.

Function
REQ-012 FSM states SHALL be IDLE(00), RUN(01), STEP(10), HALT(11).
REQ-013 IDLE->RUN when i_enable=1 and i_load_we=0; IDLE->STEP when i_step=1 and i_enable=0.
REQ-014 RUN->IDLE when i_enable=0; STEP->IDLE unconditionally after one cycle.
REQ-015 RUN or STEP ->HALT when o_Instruction==HALT_WORD and i_stall=0 at the rising edge; HALT exits only by reset.
REQ-016 PC SHALL update only in RUN or STEP; in IDLE/HALT PC holds.
REQ-017 Next-PC priority: i_stall (hold) > i_branch (target) > i_jump (target) > PC+4.
REQ-018 On the HALT transition edge PC SHALL hold (halt word remains at o_Instruction).
REQ-019 o_PC4=PC+4, o_PC8=PC+8, combinational, modulo 2^NBITS (wrap, no flag).
REQ-020 o_Instruction SHALL be asynchronous read of word PC[log2(IMEM_DEPTH)+1:2]; PC bits [1:0] ignored; upper bits beyond memory ignored (address wraps).
REQ-021 Memory writes SHALL occur at rising edge when i_load_we=1, only in IDLE; writes in other states ignored.
REQ-022 Write and read of same word in same cycle: o_Instruction SHALL show the old word until the edge.
REQ-023 o_halt SHALL equal (state==HALT), registered.

Reset
REQ-024 i_reset_n=0 SHALL immediately force PC=0, state=IDLE, o_halt=0, regardless of clock.
REQ-025 Memory contents SHALL NOT be cleared by reset; reset mid-RUN SHALL abandon fetch and restart at PC=0 in IDLE.

Configuration
REQ-026 Macro IF_STEP_MODE_EN: defined -> STEP state and i_step behave per REQ-013/014; undefined -> i_step ignored, STEP unreachable, encoding 10 unused, port retained.

Structure
REQ-027 Shared package SHALL hold state encodings, HALT_WORD default, and PC increment constant 4.
REQ-028 Instruction memory SHALL be sub-module memoria_instrucciones (one write port, one async read port); PC/FSM logic stays in etapa_if.

Verification
REQ-029 Reset, load 0x20080005 at word 0 and 0x20090007 at word 1, i_enable=1 -> o_PC 0,4,8 on successive edges; o_Instruction 0x20080005 then 0x20090007.
REQ-030 RUN at PC=0x10 with i_stall=1 for 2 cycles -> o_PC stays 0x10 both cycles, then 0x14.
REQ-031 Same cycle i_branch=1 target 0x40 and i_jump=1 target 0x80 -> next o_PC=0x40; i_stall=1 with i_branch=1 -> PC holds.
REQ-032 HALT_WORD loaded at word 3, run -> o_PC stops at 0xC, o_halt=1, o_state=11, i_enable toggles have no effect.
REQ-033 IF_STEP_MODE_EN defined, IDLE, three i_step pulses -> o_PC 4,8,0xC, o_state returns 00 after each; undefined -> o_PC stays 0.
REQ-034 Assert i_reset_n=0 mid-RUN between edges at PC=0x24 -> o_PC=0 and o_state=00 before next edge; memory words unchanged on rerun.

Source files
------------

// File: rtl/etapa_if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// the default halt instruction and the PC increment.
package etapa_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } if_state_e;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam int unsigned PC_INC        = 4;

endpackage

// File: rtl/etapa_if_memoria.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are never reset, so a program survives a core reset.
module memoria_instrucciones #(
    parameter int NBITS = 32,
    parameter int DEPTH = 256
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [NBITS-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [NBITS-1:0]         o_rdata
);

    logic [NBITS-1:0] mem_q [DEPTH];

    // Word write on the rising edge; a same-word read sees the old value until then.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/etapa_if.sv
// Instruction-fetch stage: PC register, run/step/halt sequencing and the
// instruction memory instance.
// Optional feature macro: IF_STEP_MODE_EN enables single-step (STEP state).
//
// state | meaning
// IDLE  | PC held, instruction memory may be loaded
// RUN   | PC advances every cycle (stall/branch/jump aware)
// STEP  | one PC advance, then back to IDLE
// HALT  | halt word fetched; PC frozen until reset
module etapa_if
    import etapa_if_pkg::*;
#(
    parameter int               NBITS      = 32,
    parameter int               IMEM_DEPTH = 256,
    parameter logic [NBITS-1:0] HALT_WORD  = NBITS'(HALT_WORD_DEF)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_enable,
    input  logic                          i_step,
    input  logic                          i_load_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_load_addr,
    input  logic [NBITS-1:0]              i_load_data,
    input  logic                          i_stall,
    input  logic                          i_branch,
    input  logic [NBITS-1:0]              i_branch_target,
    input  logic                          i_jump,
    input  logic [NBITS-1:0]              i_jump_target,
    output logic [NBITS-1:0]              o_PC,
    output logic [NBITS-1:0]              o_PC4,
    output logic [NBITS-1:0]              o_PC8,
    output logic [NBITS-1:0]              o_Instruction,
    output logic                          o_halt,
    output logic [1:0]                    o_state
);

    localparam int AW = $clog2(IMEM_DEPTH);

    if_state_e        state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic             halt_q;
    logic             fetching;
    logic             halt_hit;
    logic             mem_we;

`ifndef IF_STEP_MODE_EN
    // Port kept for a uniform interface; single-step is compiled out.
    logic step_unused;
    assign step_unused = i_step;
`endif

    // Loads are only honoured while the core is parked.
    assign mem_we = i_load_we && (state_q == ST_IDLE);

    memoria_instrucciones #(
        .NBITS (NBITS),
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (pc_q[AW+1:2]),
        .o_rdata (o_Instruction)
    );

    assign fetching = (state_q == ST_RUN) || (state_q == ST_STEP);
    // A stalled halt word is not yet committed; the halt edge also freezes the PC.
    assign halt_hit = fetching && (o_Instruction == HALT_WORD) && !i_stall;

    // Next-state and next-PC selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && !i_load_we) begin
                    state_d = ST_RUN;
                end
`ifdef IF_STEP_MODE_EN
                else if (i_step && !i_enable) begin
                    state_d = ST_STEP;
                end
`endif
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_d = ST_HALT;
                end else if (!i_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_d = halt_hit ? ST_HALT : ST_IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (fetching && !halt_hit) begin
            if (i_stall) begin
                pc_d = pc_q;
            end else if (i_branch) begin
                pc_d = i_branch_target;
            end else if (i_jump) begin
                pc_d = i_jump_target;
            end else begin
                pc_d = o_PC4;
            end
        end
    end

    // State, PC and halt flag registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halt_q  <= (state_d == ST_HALT);
        end
    end

    assign o_PC    = pc_q;
    assign o_PC4   = pc_q + NBITS'(PC_INC);
    assign o_PC8   = pc_q + NBITS'(2 * PC_INC);
    assign o_halt  = halt_q;
    assign o_state = state_q;

endmodule
